// File: rtl/dly_scan_ctrl.sv
// Timing-in controller for a shift-register delay line: sweeps every delay select,
// counts sig/ref coincidences per setting and commits the delay with the highest count.
module dly_scan_ctrl #(
    parameter int unsigned MXDLY = 4,
    parameter int unsigned MXWIN = 12,
    parameter int unsigned MXCNT = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic             clr_result_i,
    input  logic [MXWIN-1:0] win_len_i,
    input  logic [MXDLY-1:0] cfg_delay_i,
    input  logic             sig_dly_i,
    input  logic             ref_i,
    output logic [MXDLY-1:0] delay_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_vld_o,
    output logic [MXDLY-1:0] best_delay_o,
    output logic [MXCNT-1:0] best_count_o
);

    localparam int unsigned MXSR = 1 << MXDLY;
    localparam int unsigned TW   = (MXWIN > MXDLY) ? MXWIN : MXDLY;

    typedef enum logic [2:0] {StIdle, StSettle, StCount, StCompare, StDone} state_e;

    state_e           state_q, state_d;
    logic [MXDLY-1:0] step_q, step_d;
    logic [TW-1:0]    tmr_q, tmr_d;
    logic [MXWIN-1:0] win_q, win_d;
    logic [MXCNT-1:0] cnt_q, cnt_d;
    logic [MXCNT-1:0] run_cnt_q, run_cnt_d;
    logic [MXDLY-1:0] run_dly_q, run_dly_d;
    logic             result_vld_q, result_vld_d;
    logic [MXDLY-1:0] best_delay_q, best_delay_d;
    logic [MXCNT-1:0] best_count_q, best_count_d;
    logic [MXDLY-1:0] delay_q, delay_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             take;

    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        tmr_d        = tmr_q;
        win_d        = win_q;
        cnt_d        = cnt_q;
        run_cnt_d    = run_cnt_q;
        run_dly_d    = run_dly_q;
        result_vld_d = result_vld_q;
        best_delay_d = best_delay_q;
        best_count_d = best_count_q;
        take         = (step_q == '0) || (cnt_q > run_cnt_q);

        unique case (state_q)
            StIdle: begin
                if (clr_result_i) result_vld_d = 1'b0;
                if (start_i) begin
                    state_d = StSettle;
                    step_d  = '0;
                    tmr_d   = '0;
                    cnt_d   = '0;
                    win_d   = (win_len_i == '0) ? MXWIN'(1) : win_len_i;
                end
            end
            StSettle: begin
                if (tmr_q == TW'(MXSR - 1)) begin
                    state_d = StCount;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCount: begin
                if (sig_dly_i && ref_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
                if (tmr_q == TW'(win_q - 1'b1)) begin
                    state_d = StCompare;
                    tmr_d   = '0;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            StCompare: begin
                if (take) begin
                    run_cnt_d = cnt_q;
                    run_dly_d = step_q;
                end
                if (step_q == {MXDLY{1'b1}}) begin
                    // Commit lands on the same edge that raises done.
                    state_d      = StDone;
                    best_delay_d = run_dly_d;
                    best_count_d = run_cnt_d;
                    result_vld_d = 1'b1;
                end else begin
                    state_d = StSettle;
                    step_d  = step_q + 1'b1;
                    tmr_d   = '0;
                    cnt_d   = '0;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        if (abort_i && (state_q != StIdle)) begin
            state_d      = StIdle;
            result_vld_d = result_vld_q;
            best_delay_d = best_delay_q;
            best_count_d = best_count_q;
        end

        // Decide on next state so delay switches on the same edge busy changes.
        if (state_d == StIdle) begin
            delay_d = result_vld_d ? best_delay_d : cfg_delay_i;
        end else begin
            delay_d = step_d;
        end
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= StIdle;
            step_q       <= '0;
            tmr_q        <= '0;
            win_q        <= MXWIN'(1);
            cnt_q        <= '0;
            run_cnt_q    <= '0;
            run_dly_q    <= '0;
            result_vld_q <= 1'b0;
            best_delay_q <= '0;
            best_count_q <= '0;
            delay_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            tmr_q        <= tmr_d;
            win_q        <= win_d;
            cnt_q        <= cnt_d;
            run_cnt_q    <= run_cnt_d;
            run_dly_q    <= run_dly_d;
            result_vld_q <= result_vld_d;
            best_delay_q <= best_delay_d;
            best_count_q <= best_count_d;
            delay_q      <= delay_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign delay_o      = delay_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign result_vld_o = result_vld_q;
    assign best_delay_o = best_delay_q;
    assign best_count_o = best_count_q;

endmodule

// File: tb/tb_dly_scan_ctrl.sv
// Directed bench for dly_scan_ctrl: a 16-bit-counter instance and a 4-bit-counter
// instance share stimulus; the delay line is modelled as a pattern on the delay select.
module tb_dly_scan_ctrl;

    logic        clk = 1'b0;
    logic        reset, start, abort, clr_result, ref_s;
    logic [11:0] win_len;
    logic [3:0]  cfg_delay;
    int          mode;

    logic [3:0]  dly_m, bd_m, dly_s, bd_s;
    logic        busy_m, done_m, vld_m, busy_s, done_s, vld_s;
    logic [15:0] bc_m;
    logic [3:0]  bc_s;
    logic        sig_m, sig_s;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    function automatic logic pat(input int m, input logic [3:0] d);
        case (m)
            1:       return d == 4'd7;
            2:       return (d == 4'd3) || (d == 4'd9);
            3:       return 1'b1;
            4:       return d == 4'd5;
            default: return 1'b0;
        endcase
    endfunction

    always_comb sig_m = pat(mode, dly_m);
    always_comb sig_s = pat(mode, dly_s);

    dly_scan_ctrl #(.MXDLY(4), .MXWIN(12), .MXCNT(16)) u_dut (
        .clock_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .clr_result_i(clr_result), .win_len_i(win_len), .cfg_delay_i(cfg_delay),
        .sig_dly_i(sig_m), .ref_i(ref_s), .delay_o(dly_m), .busy_o(busy_m),
        .done_o(done_m), .result_vld_o(vld_m), .best_delay_o(bd_m), .best_count_o(bc_m)
    );

    dly_scan_ctrl #(.MXDLY(4), .MXWIN(12), .MXCNT(4)) u_sat (
        .clock_i(clk), .reset_i(reset), .start_i(start), .abort_i(abort),
        .clr_result_i(clr_result), .win_len_i(win_len), .cfg_delay_i(cfg_delay),
        .sig_dly_i(sig_s), .ref_i(ref_s), .delay_o(dly_s), .busy_o(busy_s),
        .done_o(done_s), .result_vld_o(vld_s), .best_delay_o(bd_s), .best_count_o(bc_s)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Full scan: checks start latency, done position, commit and return to IDLE.
    task automatic run_scan(input string tag, input int exp_lat, input int exp_bd,
                            input int exp_bc, input bit poke);
        int lat;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_busy_rise"}, busy_m, 1);
        chk({tag, "_delay0"}, dly_m, 0);
        lat = 0;
        while (!done_m && lat < 2000) begin
            if (poke && lat == 100) start = 1'b1;
            tick();
            start = 1'b0;
            lat++;
        end
        chk({tag, "_done_lat"}, lat, exp_lat);
        chk({tag, "_busy_at_done"}, busy_m, 1);
        chk({tag, "_vld"}, vld_m, 1);
        chk({tag, "_best_delay"}, bd_m, exp_bd);
        chk({tag, "_best_count"}, bc_m, exp_bc);
        tick();
        chk({tag, "_busy_fall"}, busy_m, 0);
        chk({tag, "_done_pulse"}, done_m, 0);
        chk({tag, "_idle_delay"}, dly_m, exp_bd);
    endtask

    initial begin
        bit saw_done;
        reset = 1'b1; start = 1'b0; abort = 1'b0; clr_result = 1'b0;
        ref_s = 1'b1; win_len = 12'd10; cfg_delay = 4'd6; mode = 0;
        tick_n(2);
        chk("rst_busy", busy_m, 0);
        chk("rst_done", done_m, 0);
        chk("rst_vld", vld_m, 0);
        chk("rst_bd", bd_m, 0);
        chk("rst_bc", bc_m, 0);
        chk("rst_delay", dly_m, 0);
        reset = 1'b0;
        tick();
        chk("cfg_track", dly_m, 6);

        mode = 1;
        run_scan("peak", 432, 7, 10, 1'b0);

        mode = 2;
        run_scan("tie", 432, 3, 10, 1'b1);

        mode = 3; win_len = 12'd20;
        run_scan("sat", 592, 0, 20, 1'b0);
        chk("sat_small_cnt", bc_s, 15);
        chk("sat_small_vld", vld_s, 1);

        mode = 0; win_len = 12'd0;
        run_scan("zero", 288, 0, 0, 1'b0);

        // Abort during step 8 COUNT keeps the prior delay-5 result.
        mode = 4; win_len = 12'd10;
        run_scan("prior", 432, 5, 10, 1'b0);
        mode = 1;
        start = 1'b1;
        tick();
        start = 1'b0;
        win_len = 12'd3;
        tick_n(235);
        chk("abort_step8", dly_m, 8);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_busy", busy_m, 0);
        chk("abort_bd", bd_m, 5);
        chk("abort_bc", bc_m, 10);
        chk("abort_delay", dly_m, 5);
        saw_done = done_m;
        for (int i = 0; i < 5; i++) begin
            tick();
            saw_done = saw_done | done_m;
        end
        chk("abort_no_done", saw_done, 0);

        cfg_delay = 4'd12;
        clr_result = 1'b1;
        tick();
        clr_result = 1'b0;
        chk("clr_vld", vld_m, 0);
        tick();
        chk("clr_delay", dly_m, 12);

        win_len = 12'd10;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick_n(110);
        chk("mid_step4", dly_m, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_busy", busy_m, 0);
        chk("mid_rst_done", done_m, 0);
        chk("mid_rst_vld", vld_m, 0);
        chk("mid_rst_delay", dly_m, 0);
        chk("mid_rst_bc", bc_m, 0);
        tick();
        run_scan("post_rst", 432, 7, 10, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
